note_sequencer: RTL and testbench
=================================

NOTE_SEQUENCER -- requirements
Module: note_sequencer

Interface
REQ-001 Parameter DEPTH, 16, number of note slots; power of two, 2..256.
REQ-002 Parameter TICKS_PER_NOTE, 25000000, clk cycles each played note lasts (0.5 s at 50 MHz); minimum 2.
REQ-003 Parameter FREQ_W, 32, width of freq_out.
REQ-004 clk  input  1  system clock, 50 MHz, all logic rising-edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 note_data  input  4  note code; 0..11 = C..B, 12..15 = rest.
REQ-007 octave_data  input  2  octave select 0..3.
REQ-008 rec_stb  input  1  one-cycle pulse; store {octave_data, note_data} in next slot.
REQ-009 clear  input  1  one-cycle pulse; empty the sequence.
REQ-010 play_start  input  1  one-cycle pulse; begin playback from slot 0.
REQ-011 stop  input  1  one-cycle pulse; abort playback.
REQ-012 loop  input  1  level; wrap to slot 0 after last note (only when NOTE_SEQ_LOOP_EN defined).
REQ-013 freq_out  output  FREQ_W  frequency of sounding note in Hz; 0 = silence.
REQ-014 playing  output  1  high while in PLAY.
REQ-015 note_idx  output  log2(DEPTH)  slot currently playing.
REQ-016 count  output  log2(DEPTH)+1  number of stored notes.
REQ-017 full  output  1  count == DEPTH.

Function
REQ-018 FSM SHALL have two states, IDLE and PLAY; all outputs registered.
REQ-019 In IDLE, rec_stb with full low SHALL write slot[count] and increment count next cycle; with full high SHALL be ignored.
REQ-020 clear in IDLE SHALL set count to 0 next cycle; slot contents need not be erased; clear and rec_stb together: clear wins.
REQ-021 rec_stb and clear in PLAY SHALL be ignored.
REQ-022 play_start in IDLE with count > 0 SHALL enter PLAY; the next cycle playing=1, note_idx=0, freq_out=f(slot[0]); with count = 0 SHALL be ignored.
REQ-023 Each note SHALL hold freq_out for exactly TICKS_PER_NOTE cycles, then advance note_idx by 1 and load the next frequency in the same cycle.
REQ-024 After slot[count-1] completes, without loop wrap: next cycle IDLE, playing=0, freq_out=0, note_idx=0.
REQ-025 stop SHALL force IDLE next cycle (freq_out=0, playing=0, note_idx=0); stop has priority over play_start and note advance in the same cycle.
REQ-026 play_start during PLAY SHALL be ignored.
REQ-027 f(entry) = BASE[note] << octave, zero-extended to FREQ_W; BASE = 131,139,147,156,165,175,185,196,208,220,233,247 Hz (octave 0 = C3..B3); rest codes give 0.
REQ-028 Tick counter width SHALL be clog2(TICKS_PER_NOTE); no overflow permitted.

Reset
REQ-029 reset low SHALL asynchronously force IDLE, count=0, full=0, playing=0, note_idx=0, freq_out=0, tick counter=0.
REQ-030 Reset mid-PLAY SHALL silence freq_out immediately (asynchronously) and discard the stored sequence.
REQ-031 Slot storage need not be reset; deassertion is assumed synchronised externally.

Configuration
REQ-032 Macro NOTE_SEQ_LOOP_EN: when defined, reaching end of slot[count-1] with loop=1 SHALL wrap to note_idx=0 with no gap cycle and playing held high; loop sampled at that boundary only.
REQ-033 When NOTE_SEQ_LOOP_EN is undefined, loop input SHALL be ignored and playback always ends per REQ-024.

Verification (bench uses DEPTH=4, TICKS_PER_NOTE=4)
REQ-034 Record {0,9},{1,0},{2,12}; play_start -> freq_out 220 for 4 cycles, 262 for 4, 0 (rest) for 4, then playing=0, freq_out=0.
REQ-035 Five rec_stb pulses -> count=4, full=1 after fourth; fifth leaves slot contents and count unchanged.
REQ-036 Stop asserted on 2nd cycle of note 1 -> next cycle IDLE, freq_out=0, note_idx=0; stop+play_start same cycle in IDLE -> stays IDLE.
REQ-037 play_start with count=0, and clear+rec_stb same cycle -> no PLAY entry; count=0.
REQ-038 NOTE_SEQ_LOOP_EN defined, 2 notes, loop=1 -> note_idx sequence 0,1,0,1 with playing continuously high; loop dropped -> ends after current pass.
REQ-039 reset pulsed low mid-note -> freq_out=0 before next clk edge; count=0 after release.

Source files
------------

// File: rtl/note_sequencer.sv
// note_sequencer: records up to DEPTH note/octave entries and plays them back as a frequency in Hz.
// Define NOTE_SEQ_LOOP_EN to let the loop input wrap playback to slot 0 after the last note.
module note_sequencer #(
    parameter int DEPTH          = 16,
    parameter int TICKS_PER_NOTE = 25000000,
    parameter int FREQ_W         = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [3:0]                note_data,
    input  logic [1:0]                octave_data,
    input  logic                      rec_stb,
    input  logic                      clear,
    input  logic                      play_start,
    input  logic                      stop,
    input  logic                      loop,
    output logic [FREQ_W-1:0]         freq_out,
    output logic                      playing,
    output logic [$clog2(DEPTH)-1:0]  note_idx,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      full
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TICKS_PER_NOTE);
    localparam logic [TW-1:0] LAST_TICK = TW'(TICKS_PER_NOTE - 1);
    localparam logic [AW:0]   FULL_CNT  = (AW+1)'(DEPTH);

    typedef enum logic {IDLE, PLAY} state_t;

    state_t              r_state, w_state_n;
    logic [5:0]          r_slot [DEPTH];
    logic [AW:0]         r_count, w_count_n;
    logic [AW-1:0]       r_idx, w_idx_n, w_idx_inc;
    logic [TW-1:0]       r_tick, w_tick_n;
    logic [FREQ_W-1:0]   r_freq, w_freq_n;
    logic                r_full, w_full_n;
    logic                w_we, w_last, w_wrap;

    function automatic logic [FREQ_W-1:0] note_freq(input logic [5:0] e);
        logic [8:0] b;
        case (e[3:0])
            4'd0:    b = 9'd131;
            4'd1:    b = 9'd139;
            4'd2:    b = 9'd147;
            4'd3:    b = 9'd156;
            4'd4:    b = 9'd165;
            4'd5:    b = 9'd175;
            4'd6:    b = 9'd185;
            4'd7:    b = 9'd196;
            4'd8:    b = 9'd208;
            4'd9:    b = 9'd220;
            4'd10:   b = 9'd233;
            4'd11:   b = 9'd247;
            default: b = 9'd0;
        endcase
        return FREQ_W'(b) << e[5:4];
    endfunction

`ifdef NOTE_SEQ_LOOP_EN
    assign w_wrap = loop;
`else
    assign w_wrap = loop & 1'b0;
`endif

    assign w_idx_inc = r_idx + AW'(1);
    assign w_last    = {1'b0, r_idx} == r_count - (AW+1)'(1);
    assign w_full_n  = w_count_n == FULL_CNT;

    always_comb begin
        w_state_n = r_state;
        w_count_n = r_count;
        w_idx_n   = r_idx;
        w_tick_n  = r_tick;
        w_freq_n  = r_freq;
        w_we      = 1'b0;
        if (r_state == IDLE) begin
            if (clear) begin
                w_count_n = '0;
            end else if (rec_stb && !r_full) begin
                w_we      = 1'b1;
                w_count_n = r_count + (AW+1)'(1);
            end
            // clear in the same cycle would empty the sequence we are about to play
            if (play_start && !stop && !clear && r_count != '0) begin
                w_state_n = PLAY;
                w_idx_n   = '0;
                w_tick_n  = '0;
                w_freq_n  = note_freq(r_slot[0]);
            end
        end else if (stop) begin
            w_state_n = IDLE;
            w_idx_n   = '0;
            w_tick_n  = '0;
            w_freq_n  = '0;
        end else if (r_tick != LAST_TICK) begin
            w_tick_n = r_tick + TW'(1);
        end else begin
            w_tick_n = '0;
            if (!w_last) begin
                w_idx_n  = w_idx_inc;
                w_freq_n = note_freq(r_slot[w_idx_inc]);
            end else if (w_wrap) begin
                w_idx_n  = '0;
                w_freq_n = note_freq(r_slot[0]);
            end else begin
                w_state_n = IDLE;
                w_idx_n   = '0;
                w_freq_n  = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_count <= '0;
            r_idx   <= '0;
            r_tick  <= '0;
            r_freq  <= '0;
            r_full  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_count <= w_count_n;
            r_idx   <= w_idx_n;
            r_tick  <= w_tick_n;
            r_freq  <= w_freq_n;
            r_full  <= w_full_n;
        end
    end

    always_ff @(posedge clk) begin
        if (w_we) r_slot[r_count[AW-1:0]] <= {octave_data, note_data};
    end

    assign freq_out = r_freq;
    assign playing  = r_state == PLAY;
    assign note_idx = r_idx;
    assign count    = r_count;
    assign full     = r_full;
endmodule

// File: tb/tb_note_sequencer.sv
// tb_note_sequencer: directed plus randomized checks of note_sequencer against a queue-based playback model.
module tb_note_sequencer;
    localparam int D = 4;
    localparam int T = 4;
    localparam int FW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [3:0]    note_data = '0;
    logic [1:0]    octave_data = '0;
    logic          rec_stb = 1'b0, clear = 1'b0, play_start = 1'b0, stop = 1'b0, loop = 1'b0;
    logic [FW-1:0] freq_out;
    logic          playing;
    logic [1:0]    note_idx;
    logic [2:0]    count;
    logic          full;

    int checks = 0;
    int errors = 0;
    int mq[$];
    int base_hz[12] = '{131, 139, 147, 156, 165, 175, 185, 196, 208, 220, 233, 247};

    note_sequencer #(.DEPTH(D), .TICKS_PER_NOTE(T), .FREQ_W(FW)) dut (
        .clk(clk), .reset(reset), .note_data(note_data), .octave_data(octave_data),
        .rec_stb(rec_stb), .clear(clear), .play_start(play_start), .stop(stop), .loop(loop),
        .freq_out(freq_out), .playing(playing), .note_idx(note_idx), .count(count), .full(full)
    );

    always #5 clk = ~clk;

    function automatic int fref(int e);
        int n = e % 16;
        return (n > 11) ? 0 : base_hz[n] * (1 << (e / 16));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_idle(string tag);
        check({tag, "_playing"}, 32'(playing), 0);
        check({tag, "_freq"}, freq_out, 0);
        check({tag, "_idx"}, 32'(note_idx), 0);
    endtask

    task automatic rec(int e);
        note_data = 4'(e % 16);
        octave_data = 2'(e / 16);
        rec_stb = 1'b1;
        tick();
        rec_stb = 1'b0;
        if (mq.size() < D) mq.push_back(e);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        mq.delete();
        check("clear_count", 32'(count), 0);
    endtask

    // plays the model queue once, poking ignored inputs mid-note
    task automatic play_once(string tag);
        play_start = 1'b1;
        tick();
        play_start = 1'b0;
        for (int i = 0; i < mq.size(); i++) begin
            for (int c = 0; c < T; c++) begin
                check({tag, "_playing"}, 32'(playing), 1);
                check({tag, "_idx"}, 32'(note_idx), 32'(i));
                check({tag, "_freq"}, freq_out, 32'(fref(mq[i])));
                {rec_stb, clear, play_start} = (i == 0 && c == 1) ? 3'b111 : 3'b000;
                tick();
            end
        end
        {rec_stb, clear, play_start} = 3'b000;
        check_idle({tag, "_end"});
        check({tag, "_count"}, 32'(count), 32'(mq.size()));
    endtask

    initial begin
        repeat (2) tick();
        check_idle("rst");
        check("rst_count", 32'(count), 0);
        check("rst_full", 32'(full), 0);
        reset = 1'b1;
        tick();

        rec(9); rec(16); rec(32 + 12);
        check("rec3_count", 32'(count), 3);
        play_start = 1'b1;
        tick();
        play_start = 1'b0;
        check("dir_first_freq", freq_out, 220);
        tick(); tick(); tick(); tick();
        check("dir_second_freq", freq_out, 262);
        tick(); tick(); tick(); tick();
        check("dir_rest_freq", freq_out, 0);
        check("dir_rest_playing", 32'(playing), 1);
        tick(); tick(); tick(); tick();
        check_idle("dir_end");
        play_once("dir");

        do_clear();
        for (int k = 0; k < 5; k++) begin
            rec(int'($urandom_range(0, 63)));
            check("fill_count", 32'(count), 32'((k < D) ? k + 1 : D));
            check("fill_full", 32'(full), 32'(k >= D - 1));
        end
        play_once("fill");

        play_start = 1'b1;
        tick();
        play_start = 1'b0;
        repeat (T + 1) tick();
        check("stop_pre_idx", 32'(note_idx), 1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check_idle("stop");
        {stop, play_start} = 2'b11;
        tick();
        {stop, play_start} = 2'b00;
        check_idle("stop_start");
        check("stop_count", 32'(count), D);

        do_clear();
        play_start = 1'b1;
        tick();
        play_start = 1'b0;
        check("empty_play", 32'(playing), 0);
        {clear, rec_stb} = 2'b11;
        tick();
        {clear, rec_stb} = 2'b00;
        check("clr_rec_count", 32'(count), 0);
        play_start = 1'b1;
        tick();
        play_start = 1'b0;
        check("clr_rec_play", 32'(playing), 0);

        for (int r = 0; r < 6; r++) begin
            do_clear();
            for (int k = 0, n = int'($urandom_range(1, D)); k < n; k++) rec(int'($urandom_range(0, 63)));
            play_once("rnd");
        end

        do_clear();
        rec(int'($urandom_range(0, 63)));
        rec(int'($urandom_range(0, 63)));
        loop = 1'b1;
`ifdef NOTE_SEQ_LOOP_EN
        play_start = 1'b1;
        tick();
        play_start = 1'b0;
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 2; i++) begin
                for (int c = 0; c < T; c++) begin
                    if (p == 1 && i == 0 && c == 1) loop = 1'b0;
                    check("loop_playing", 32'(playing), 1);
                    check("loop_idx", 32'(note_idx), 32'(i));
                    check("loop_freq", freq_out, 32'(fref(mq[i])));
                    tick();
                end
            end
        end
        check_idle("loop_end");
`else
        play_once("noloop");
`endif
        loop = 1'b0;

        play_start = 1'b1;
        tick();
        play_start = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        check("arst_freq", freq_out, 0);
        check("arst_playing", 32'(playing), 0);
        tick();
        reset = 1'b1;
        tick();
        check("arst_count", 32'(count), 0);
        check_idle("arst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
